aes_round_scheduler: RTL and testbench

AES_ROUND_SCHEDULER -- requirements
Module: aes_round_scheduler

---
 rtl/aes_sched_pkg.sv | 17 +
 rtl/aes_slot_pipe.sv | 34 +++
 rtl/aes_round_scheduler.sv | 113 +++++++++++
 tb/tb_aes_round_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES round scheduler: slot record layout and round-count defaults.
package aes_sched_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int ROUND_W       = 4;
    localparam int MAX_TAG_W     = 16;

    // valid is the MSB so generic pipes can find it without knowing the layout
    typedef struct packed {
        logic                 valid;
        logic [ROUND_W-1:0]   round;
        logic [MAX_TAG_W-1:0] tag;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

endpackage

// File: rtl/aes_slot_pipe.sv
// Fixed-depth delay line of slot records, cleared by a synchronous active-low reset.
// The MSB of each record is its valid bit; any_valid reports whether any stage holds a block.
module aes_slot_pipe
    import aes_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = SLOT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             any_valid
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i][WIDTH-1];
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/aes_round_scheduler.sv
// Issue scheduler for an iterated AES datapath: a ring of round-loop slots plus a final-round pipe.
// Optional performance counters are enabled with the AES_SCHED_PERF_EN macro.
module aes_round_scheduler
    import aes_sched_pkg::*;
#(
    parameter int LOOP_DEPTH  = 4,
    parameter int FINAL_DEPTH = 3,
    parameter int NUM_ROUNDS  = AES128_ROUNDS,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_ready,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               loop_en,
    output logic               loop_sel,
    output logic [ROUND_W-1:0] loop_round,
    output logic [TAG_W-1:0]   loop_tag,
    output logic               final_en,
    output logic [TAG_W-1:0]   final_tag,
    output logic               out_valid,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
`ifdef AES_SCHED_PERF_EN
    ,
    output logic [15:0]        perf_admit_cnt,
    output logic [15:0]        perf_stall_cnt
`endif
);

    localparam logic [ROUND_W-1:0] LAST_LOOP_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    slot_t            ring_in;
    slot_t            ring_exit;
    logic             ring_busy;
    logic [TAG_W:0]   fin_in;
    logic [TAG_W:0]   fin_out;
    logic             fin_busy;
    logic             recirc;
    logic             to_final;
    logic             admit;

    // Recirculation owns the entry slot, so it pre-empts admission in the same cycle.
    assign recirc   = rst_n & ring_exit.valid & (ring_exit.round < LAST_LOOP_ROUND);
    assign to_final = rst_n & ring_exit.valid & ~(ring_exit.round < LAST_LOOP_ROUND);
    assign in_ready = rst_n & key_ready & ~recirc;
    assign admit    = in_valid & in_ready;

    always_comb begin
        ring_in = '0;
        if (recirc) begin
            ring_in       = ring_exit;
            ring_in.round = ring_exit.round + ROUND_W'(1);
        end else if (admit) begin
            ring_in.valid = 1'b1;
            ring_in.round = ROUND_W'(1);
            ring_in.tag   = MAX_TAG_W'(in_tag);
        end
    end

    assign loop_en    = ring_in.valid;
    assign loop_sel   = recirc;
    assign loop_round = ring_in.round;
    assign loop_tag   = ring_in.tag[TAG_W-1:0];

    assign final_en  = to_final;
    assign final_tag = to_final ? ring_exit.tag[TAG_W-1:0] : '0;
    assign fin_in    = {final_en, final_tag};

    aes_slot_pipe #(
        .DEPTH (LOOP_DEPTH),
        .WIDTH (SLOT_W)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (ring_in),
        .q         (ring_exit),
        .any_valid (ring_busy)
    );

    aes_slot_pipe #(
        .DEPTH (FINAL_DEPTH),
        .WIDTH (TAG_W + 1)
    ) u_final (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (fin_in),
        .q         (fin_out),
        .any_valid (fin_busy)
    );

    assign out_valid = rst_n & fin_out[TAG_W];
    assign out_tag   = fin_out[TAG_W-1:0];
    assign busy      = ring_busy | fin_busy;

`ifdef AES_SCHED_PERF_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_admit_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (admit && (perf_admit_cnt != 16'hFFFF))
                perf_admit_cnt <= perf_admit_cnt + 16'd1;
            if (in_valid && !in_ready && (perf_stall_cnt != 16'hFFFF))
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Self-checking bench for aes_round_scheduler: per-cycle expectation tables plus an output scoreboard.
// Counter checks are compiled in when AES_SCHED_PERF_EN is defined.
module tb_aes_round_scheduler;

    localparam int OUT_LATENCY = 39;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_ready;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_tag;
    logic       loop_en;
    logic       loop_sel;
    logic [3:0] loop_round;
    logic [3:0] loop_tag;
    logic       final_en;
    logic [3:0] final_tag;
    logic       out_valid;
    logic [3:0] out_tag;
    logic       busy;
`ifdef AES_SCHED_PERF_EN
    logic [15:0] perf_admit_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    aes_round_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_ready  (key_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tag     (in_tag),
        .loop_en    (loop_en),
        .loop_sel   (loop_sel),
        .loop_round (loop_round),
        .loop_tag   (loop_tag),
        .final_en   (final_en),
        .final_tag  (final_tag),
        .out_valid  (out_valid),
        .out_tag    (out_tag),
        .busy       (busy)
`ifdef AES_SCHED_PERF_EN
        ,
        .perf_admit_cnt (perf_admit_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        int         cyc;
        logic       in_ready;
        logic       loop_en;
        logic       loop_sel;
        logic [3:0] loop_round;
        logic [3:0] loop_tag;
        logic       final_en;
        logic [3:0] final_tag;
        logic       out_valid;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0] tag;
        int         due;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  sb_head;
    int   n_compared = 0;
    int   n_failed = 0;
    int   cyc = 0;
    int   scen = 0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s scenario %0d cycle %0d: got %0h, expected %0h",
                     name, scen, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic kr, input logic iv, input logic [3:0] tg);
        rst_n     = rn;
        key_ready = kr;
        in_valid  = iv;
        in_tag    = tg;
    endtask

    function automatic vec_t mkRow(input int c, input logic ir, input logic le, input logic ls,
                                   input logic [3:0] lr, input logic [3:0] lt, input logic fe,
                                   input logic [3:0] ft, input logic ov, input logic b);
        vec_t v;
        v.cyc = c; v.in_ready = ir; v.loop_en = le; v.loop_sel = ls; v.loop_round = lr;
        v.loop_tag = lt; v.final_en = fe; v.final_tag = ft; v.out_valid = ov; v.busy = b;
        return v;
    endfunction

    task automatic checkRow(input vec_t v);
        checkOutput("in_ready",   16'(in_ready),   16'(v.in_ready));
        checkOutput("loop_en",    16'(loop_en),    16'(v.loop_en));
        checkOutput("loop_sel",   16'(loop_sel),   16'(v.loop_sel));
        checkOutput("loop_round", 16'(loop_round), 16'(v.loop_round));
        checkOutput("loop_tag",   16'(loop_tag),   16'(v.loop_tag));
        checkOutput("final_en",   16'(final_en),   16'(v.final_en));
        checkOutput("final_tag",  16'(final_tag),  16'(v.final_tag));
        checkOutput("out_valid",  16'(out_valid),  16'(v.out_valid));
        checkOutput("busy",       16'(busy),       16'(v.busy));
    endtask

    // Admissions push their expected ciphertext slot; every out_valid pops and checks tag and timing.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1)
            sb.push_back('{in_tag, cyc + OUT_LATENCY});
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_compared++;
                n_failed++;
                $display("[TB] FAIL unexpected_out scenario %0d cycle %0d: out_valid=1 tag %0h, expected no output",
                         scen, cyc, out_tag);
            end else begin
                sb_head = sb.pop_front();
                checkOutput("out_tag",   16'(out_tag), 16'(sb_head.tag));
                checkOutput("out_cycle", 16'(cyc),     16'(sb_head.due));
            end
        end
    end

    task automatic resetDut();
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hA);
        sb.delete();
        #2;
        checkOutput("rst_in_ready",  16'(in_ready),  16'd0);
        checkOutput("rst_loop_en",   16'(loop_en),   16'd0);
        checkOutput("rst_final_en",  16'(final_en),  16'd0);
        checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
        @(posedge clk); #3;
        checkOutput("rst_busy", 16'(busy), 16'd0);
    endtask

    task automatic runScenario(input int sc, input int n_cycles, input int n_blocks,
                               input logic [3:0] first_tag, input int kr_low_until, input int reset_at);
        int   admitted = 0;
        logic iv;
        for (int t = 0; t < n_cycles; t++) begin
            @(posedge clk); #1;
            cyc  = t;
            scen = sc;
            iv   = (admitted < n_blocks);
            applyStimulus(t != reset_at, t >= kr_low_until, iv, first_tag + 4'(admitted));
            if (t == reset_at) sb.delete();
            #2;
            if (iv && in_ready === 1'b1) admitted++;
            foreach (vecs[i]) if (vecs[i].cyc == t) checkRow(vecs[i]);
`ifdef AES_SCHED_PERF_EN
            if (sc == 3 && t == 11) begin
                checkOutput("perf_stall_after_wait", perf_stall_cnt, 16'd10);
                checkOutput("perf_admit_after_wait", perf_admit_cnt, 16'd1);
            end
`endif
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);

        // Single block, tag 3: eight recirculations, then final pipe, then output.
        vecs.delete();
        vecs.push_back(mkRow(0, 1, 1, 0, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mkRow(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mkRow(4 * k, 0, 1, 1, 4'(k + 1), 3, 0, 0, 0, 1));
        vecs.push_back(mkRow(36, 1, 0, 0, 0, 0, 1, 3, 0, 1));
        vecs.push_back(mkRow(39, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mkRow(40, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        resetDut();
        runScenario(1, 42, 1, 4'd3, 0, -1);
        checkOutput("sb_drained_s1", 16'(sb.size()), 16'd0);

        // Back-to-back offers, tags 0..4: ring fills, fifth block waits for the first exit.
        vecs.delete();
        for (int k = 0; k < 4; k++)
            vecs.push_back(mkRow(k, 1, 1, 0, 1, 4'(k), 0, 0, 0, (k != 0)));
        vecs.push_back(mkRow(4,  0, 1, 1, 2, 0, 0, 0, 0, 1));
        vecs.push_back(mkRow(20, 0, 1, 1, 6, 0, 0, 0, 0, 1));
        vecs.push_back(mkRow(35, 0, 1, 1, 9, 3, 0, 0, 0, 1));
        vecs.push_back(mkRow(36, 1, 1, 0, 1, 4, 1, 0, 0, 1));
        vecs.push_back(mkRow(37, 1, 0, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mkRow(39, 1, 0, 0, 0, 0, 1, 3, 1, 1));
        vecs.push_back(mkRow(40, 0, 1, 1, 2, 4, 0, 0, 1, 1));
        vecs.push_back(mkRow(43, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        resetDut();
        runScenario(2, 80, 5, 4'd0, 0, -1);
        checkOutput("sb_drained_s2", 16'(sb.size()), 16'd0);

        // Key schedule unavailable for ten cycles while a block is offered.
        vecs.delete();
        vecs.push_back(mkRow(0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkRow(5,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkRow(9,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkRow(10, 1, 1, 0, 1, 5, 0, 0, 0, 0));
        vecs.push_back(mkRow(11, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        resetDut();
        runScenario(3, 52, 1, 4'd5, 10, -1);
        checkOutput("sb_drained_s3", 16'(sb.size()), 16'd0);

        // Reset while a block is mid-flight: it must vanish without producing output.
        vecs.delete();
        vecs.push_back(mkRow(0,  1, 1, 0, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mkRow(16, 0, 1, 1, 5, 3, 0, 0, 0, 1));
        vecs.push_back(mkRow(20, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mkRow(21, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkRow(39, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkRow(60, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        resetDut();
        runScenario(4, 61, 1, 4'd3, 0, 20);
        checkOutput("sb_drained_s4", 16'(sb.size()), 16'd0);

`ifdef AES_SCHED_PERF_EN
        // Long stall: the stall counter must saturate instead of wrapping.
        vecs.delete();
        resetDut();
        runScenario(5, 70000, 1, 4'd1, 70001, -1);
        checkOutput("perf_stall_saturated", perf_stall_cnt, 16'hFFFF);
        checkOutput("perf_admit_none",      perf_admit_cnt, 16'd0);
        checkOutput("sb_drained_s5", 16'(sb.size()), 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
